// File: rtl/spm_ctrl.sv
// spm_ctrl: serial-parallel multiplier controller (LOAD, 2*WIDTH RUN shifts, DONE); define SPM_CTRL_SIGNED_EN for two's complement operands
module spm_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   mcand_in,
    input  logic [WIDTH-1:0]   mplier_in,
    output logic               spm_load,
    output logic [WIDTH-1:0]   spm_mcand,
    output logic               spm_en,
    output logic               spm_x_bit,
    input  logic               spm_p_bit,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(2*WIDTH);
    localparam logic [CW-1:0] LAST = CW'(2*WIDTH-1);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_mcand, r_mplier;
    logic [2*WIDTH-1:0] r_shift, r_product;
    logic               w_ext, w_last;
`ifdef SPM_CTRL_SIGNED_EN
    assign w_ext = r_mplier[WIDTH-1];
`else
    assign w_ext = 1'b0;
`endif
    assign w_last    = r_cnt == LAST;
    assign spm_mcand = r_mcand;
    assign product   = r_product;
    // state register
    always_ff @(posedge clk_in) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    // next-state: abort always returns to IDLE, RUN leaves after the last bit
    always_comb begin
        w_next = abort ? IDLE :
                 r_state == IDLE ? (start ? LOAD : IDLE) :
                 r_state == LOAD ? RUN :
                 r_state == RUN  ? (w_last ? DONE : RUN) : IDLE;
    end
    // outputs decoded from state; multiplier shifts right so bit 0 is always the current serial bit
    always_comb begin
        spm_load  = r_state == LOAD;
        spm_en    = r_state == RUN;
        done      = r_state == DONE;
        busy      = r_state != IDLE;
        spm_x_bit = (r_state == RUN) & r_mplier[0];
    end
    // datapath: operand latch, bit counter, product shift register and captured product
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_shift   <= '0;
            r_product <= '0;
        end else begin
            if (r_state == IDLE && start && !abort) begin
                r_mcand  <= mcand_in;
                r_mplier <= mplier_in;
            end
            if (r_state == LOAD) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end
            if (r_state == RUN && !abort) begin
                r_cnt    <= r_cnt + CW'(1);
                r_mplier <= {w_ext, r_mplier[WIDTH-1:1]};
                r_shift  <= {spm_p_bit, r_shift[2*WIDTH-1:1]};
                if (w_last) r_product <= {spm_p_bit, r_shift[2*WIDTH-1:1]};
            end
        end
    end
endmodule
